// File: rtl/psum_mem_ctrl.sv
// Partial-sum memory (PMSM) and controller closing the accumulate loop around the SFP stage.
// Optional macro PMSM_CLR_EN adds an i_clr input and a CLEAR state that zeroes the memory.
module psum_mem_ctrl #(
    parameter int bw      = 16,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int addr_bw = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
`ifdef PMSM_CLR_EN
    input  logic                  i_clr,
`endif
    input  logic                  i_start,
    input  logic [addr_bw:0]      i_len,
    input  logic                  i_acc_en,
    input  logic                  i_ofifo_valid,
    output logic                  o_ofifo_rd,
    output logic [bw*col-1:0]     o_in_pmsm,
    input  logic [bw*col-1:0]     i_sfp_out,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_host_rd,
    input  logic [addr_bw-1:0]    i_host_addr,
    output logic [bw*col-1:0]     o_host_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
`ifdef PMSM_CLR_EN
        , ST_CLEAR
`endif
    } state_t;

    localparam logic [addr_bw:0] DEPTH_N = (addr_bw + 1)'(depth);
    localparam logic [addr_bw:0] ONE_N   = (addr_bw + 1)'(1);
`ifdef PMSM_CLR_EN
    localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(depth - 1);
`endif

    state_t                r_state;
    logic [addr_bw:0]      r_n;
    logic [addr_bw:0]      r_issued;
    logic                  r_acc;
    logic [2:0]            r_vld;
    logic [addr_bw-1:0]    r_addr1;
    logic [addr_bw-1:0]    r_addr2;
    logic [addr_bw-1:0]    r_addr3;
    logic [bw*col-1:0]     r_mem [depth];
`ifdef PMSM_CLR_EN
    logic [addr_bw-1:0]    r_clr_addr;
`endif

    logic                  w_pop;
    logic [addr_bw:0]      w_issued_next;
    logic [addr_bw:0]      w_n_clip;
    logic                  w_host_en;

    assign w_pop         = (r_state == ST_RUN) && i_ofifo_valid && (r_issued < r_n);
    assign w_issued_next = r_issued + ONE_N;
    assign w_n_clip      = (i_len > DEPTH_N) ? DEPTH_N : i_len;
    assign w_host_en     = (r_state == ST_IDLE) && i_host_rd;
    assign o_ofifo_rd    = w_pop;

    // Control FSM; busy and done are registered alongside the state transitions.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_n      <= '0;
            r_issued <= '0;
            r_acc    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
`ifdef PMSM_CLR_EN
            r_clr_addr <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef PMSM_CLR_EN
                    if (i_clr) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        o_busy     <= 1'b1;
                    end else
`endif
                    if (i_start) begin
                        r_acc    <= i_acc_en;
                        r_issued <= '0;
                        r_n      <= w_n_clip;
                        o_busy   <= 1'b1;
                        if (i_len == '0) begin
                            r_state <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_pop) begin
                        r_issued <= w_issued_next;
                        if (w_issued_next == r_n) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage 3 commits its write on this same edge, so only stages 1-2 must be empty.
                    if (!r_vld[0] && !r_vld[1]) begin
                        r_state <= ST_DONE;
                        o_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
`ifdef PMSM_CLR_EN
                ST_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= ST_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Valid/address pipeline aligned with ofifo -> SFP -> write-back; in_pmsm holds through bubbles.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_vld     <= '0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_addr3   <= '0;
            o_in_pmsm <= '0;
        end else begin
            r_vld   <= {r_vld[1:0], w_pop};
            r_addr1 <= r_issued[addr_bw-1:0];
            r_addr2 <= r_addr1;
            r_addr3 <= r_addr2;
            if (r_vld[0]) begin
                o_in_pmsm <= r_acc ? r_mem[r_addr1] : '0;
            end
        end
    end

    // Memory is not reset; an asserted reset only blocks the pending write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef PMSM_CLR_EN
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_addr] <= '0;
            end else
`endif
            if (r_vld[2]) begin
                r_mem[r_addr3] <= i_sfp_out;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_host_data <= '0;
        end else if (w_host_en) begin
            o_host_data <= r_mem[i_host_addr];
        end
    end

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Directed bench for psum_mem_ctrl: behavioural ofifo and SFP (lane-wise add) around the DUT,
// with passes checked for pop count, psum timing, done timing, write-back and host reads.
module tb_psum_mem_ctrl;

    localparam int BW    = 16;
    localparam int COL   = 8;
    localparam int DEPTH = 16;
    localparam int ABW   = 4;
    localparam int VW    = BW * COL;

    logic            clock      = 1'b0;
    logic            reset      = 1'b0;
    logic            start      = 1'b0;
    logic [ABW:0]    len        = '0;
    logic            accEn      = 1'b0;
    logic            ofifoValid = 1'b0;
    logic            ofifoRd;
    logic [VW-1:0]   inPmsm;
    logic [VW-1:0]   sfpOut     = '0;
    logic            busy;
    logic            done;
    logic            hostRd     = 1'b0;
    logic [ABW-1:0]  hostAddr   = '0;
    logic [VW-1:0]   hostData;
`ifdef PMSM_CLR_EN
    logic            clr        = 1'b0;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int popCount = 0;
    int popBase  = 0;
    int wordBase = 0;
    int popCyc [64];
    int expMem [DEPTH];
    logic [VW-1:0] ofifoDout = '0;
    logic [VW-1:0] sfpStage  = '0;
    logic [VW-1:0] inLog [256];

    psum_mem_ctrl #(.bw(BW), .col(COL), .depth(DEPTH), .addr_bw(ABW)) dut (
        .i_clk        (clock),
        .i_reset      (reset),
`ifdef PMSM_CLR_EN
        .i_clr        (clr),
`endif
        .i_start      (start),
        .i_len        (len),
        .i_acc_en     (accEn),
        .i_ofifo_valid(ofifoValid),
        .o_ofifo_rd   (ofifoRd),
        .o_in_pmsm    (inPmsm),
        .i_sfp_out    (sfpOut),
        .o_busy       (busy),
        .o_done       (done),
        .i_host_rd    (hostRd),
        .i_host_addr  (hostAddr),
        .o_host_data  (hostData)
    );

    always #5 clock = ~clock;

    // Lane j of a test vector carries v*(j+1), so lane-wise sums stay linear in v.
    function automatic logic [VW-1:0] makeVec(input int v);
        logic [VW-1:0] r;
        r = '0;
        for (int j = 0; j < COL; j++) r[j*BW +: BW] = BW'(v * (j + 1));
        return r;
    endfunction

    function automatic logic [VW-1:0] vecAdd(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int j = 0; j < COL; j++) r[j*BW +: BW] = a[j*BW +: BW] + b[j*BW +: BW];
        return r;
    endfunction

    // ofifo pops word k = base*(k+1) one cycle after ofifo_rd; SFP adds psum the cycle after.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ofifoRd) begin
            ofifoDout <= makeVec(wordBase * (popCount - popBase + 1));
            popCyc[(popCount - popBase) & 63] <= cyc;
            popCount <= popCount + 1;
        end
        sfpStage <= ofifoDout;
        sfpOut   <= vecAdd(sfpStage, inPmsm);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expected);
        end
    endtask

    task automatic hostRead(input int addr, input int expVal);
        hostRd   = 1'b1;
        hostAddr = ABW'(addr);
        tick();
        hostRd = 1'b0;
        checkOutput($sformatf("host_data[%0d]", addr), hostData, makeVec(expVal));
    endtask

    // One pass: start at relative cycle 0, ofifo_valid from vpat (then held high), checks after done.
    task automatic applyStimulus(
        input string tag, input int passLen, input bit acc, input int base,
        input logic [31:0] vpat, input int patLen, input int expPops, input int expDone,
        input int midStartCyc, input bit hostAtStart, input int midHostCyc,
        input int hostAddrIn, input int expHost);
        int  cycStart, doneCyc, doneCnt, n, c, r;
        bit  finished;
        n        = (passLen > DEPTH) ? DEPTH : passLen;
        cycStart = cyc;
        popBase  = popCount;
        wordBase = base;
        for (int i = 0; i < 256; i++) inLog[i] = '0;
        start      = 1'b1;
        len        = (ABW + 1)'(passLen);
        accEn      = acc;
        ofifoValid = 1'b0;
        if (hostAtStart) begin
            hostRd   = 1'b1;
            hostAddr = ABW'(hostAddrIn);
        end
        tick();
        start  = 1'b0;
        hostRd = 1'b0;
        checkOutput({tag, " busy after start"}, VW'(busy), VW'(1));
        if (hostAtStart) checkOutput({tag, " host read with start"}, hostData, makeVec(expHost));
        doneCyc  = -1;
        doneCnt  = 0;
        finished = 1'b0;
        c        = 1;
        while (!finished) begin
            inLog[c] = inPmsm;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (midHostCyc != 0 && c == midHostCyc + 1)
                checkOutput({tag, " host_data hold"}, hostData, makeVec(expHost));
            if (doneCyc >= 0 && c == doneCyc + 1) begin
                checkOutput({tag, " busy cleared"}, VW'(busy), VW'(0));
                finished = 1'b1;
            end else if (c >= 200) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s done timeout: observed none, expected cycle %0d", tag, expDone);
                finished = 1'b1;
            end else begin
                ofifoValid = (c - 1 < patLen) ? vpat[c-1] : 1'b1;
                start      = (c == midStartCyc);
                if (c == midStartCyc) begin
                    len   = (ABW + 1)'(3);
                    accEn = 1'b1;
                end
                hostRd   = (c == midHostCyc);
                hostAddr = ABW'(hostAddrIn);
                tick();
                c++;
            end
        end
        ofifoValid = 1'b0;
        start      = 1'b0;
        hostRd     = 1'b0;
        checkOutput({tag, " pops"}, VW'(popCount - popBase), VW'(expPops));
        checkOutput({tag, " done cycle"}, VW'(doneCyc), VW'(expDone));
        checkOutput({tag, " done pulses"}, VW'(doneCnt), VW'(1));
        for (int k = 0; k < n && k < popCount - popBase; k++) begin
            r = popCyc[k] - cycStart + 2;
            if (r >= 0 && r < 256)
                checkOutput($sformatf("%s in_pmsm k=%0d", tag, k), inLog[r],
                            acc ? makeVec(expMem[k]) : '0);
        end
        for (int k = 0; k < n; k++) expMem[k] = (acc ? expMem[k] : 0) + base * (k + 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout: observed no finish, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) expMem[i] = 0;

        repeat (3) tick();
        checkOutput("reset ofifo_rd", VW'(ofifoRd), VW'(0));
        checkOutput("reset in_pmsm", inPmsm, '0);
        checkOutput("reset busy", VW'(busy), VW'(0));
        checkOutput("reset done", VW'(done), VW'(0));
        checkOutput("reset host_data", hostData, '0);
        reset = 1'b1;
        tick();

        // First pass supplies zero psums; mem becomes the ofifo words 1..4.
        applyStimulus("first", 4, 1'b0, 1, 32'hFFFF_FFFF, 32, 4, 8, 0, 1'b0, 0, 0, 0);
        for (int a = 0; a < 4; a++) hostRead(a, a + 1);

        // Accumulate 10..40; a host read during RUN must leave the last result (addr 3 = 4) in place.
        applyStimulus("accum", 4, 1'b1, 10, 32'hFFFF_FFFF, 32, 4, 8, 0, 1'b0, 2, 0, 4);
        for (int a = 0; a < 4; a++) hostRead(a, 11 * (a + 1));

        // Stalled pass: valid 1,0,0,1,0,1 -> pops at cycles 1,4,6; host read served with start.
        applyStimulus("stall", 3, 1'b1, 5, 32'h0000_0029, 6, 3, 10, 0, 1'b1, 0, 3, 44);
        checkOutput("stall in_pmsm hold", inLog[5], makeVec(11));
        hostRead(0, 16);
        hostRead(1, 32);
        hostRead(2, 48);
        hostRead(3, 44);

        applyStimulus("len0", 0, 1'b0, 7, 32'hFFFF_FFFF, 32, 0, 1, 0, 1'b0, 0, 0, 0);
        hostRead(0, 16);

        // len 20 clips to 16; a start pulse mid-pass is ignored.
        applyStimulus("len20", 20, 1'b0, 100, 32'hFFFF_FFFF, 32, 16, 20, 5, 1'b0, 0, 0, 0);
        hostRead(0, 100);
        hostRead(7, 800);
        hostRead(15, 1600);

        // Reset during RUN with two vectors popped: everything returns to reset, no write lands.
        popBase    = popCount;
        wordBase   = 1000;
        start      = 1'b1;
        len        = (ABW + 1)'(4);
        accEn      = 1'b1;
        ofifoValid = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("abort ofifo_rd before reset", VW'(ofifoRd), VW'(1));
        checkOutput("abort pops before reset", VW'(popCount - popBase), VW'(2));
        reset = 1'b0;
        tick();
        checkOutput("abort ofifo_rd", VW'(ofifoRd), VW'(0));
        checkOutput("abort in_pmsm", inPmsm, '0);
        checkOutput("abort busy", VW'(busy), VW'(0));
        checkOutput("abort done", VW'(done), VW'(0));
        checkOutput("abort host_data", hostData, '0);
        reset      = 1'b1;
        ofifoValid = 1'b0;
        repeat (5) tick();
        for (int a = 0; a < 4; a++) hostRead(a, expMem[a]);

`ifdef PMSM_CLR_EN
        // clr together with start: the clear runs, the start is dropped.
        begin
            int busyCnt, doneCyc;
            popBase    = popCount;
            start      = 1'b1;
            len        = (ABW + 1)'(4);
            accEn      = 1'b0;
            ofifoValid = 1'b1;
            clr        = 1'b1;
            tick();
            start   = 1'b0;
            clr     = 1'b0;
            busyCnt = 0;
            doneCyc = -1;
            for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
                if (done) doneCyc = c;
                else if (busy) busyCnt++;
                if (doneCyc < 0) tick();
            end
            ofifoValid = 1'b0;
            checkOutput("clear done cycle", VW'(doneCyc), VW'(17));
            checkOutput("clear busy cycles", VW'(busyCnt), VW'(16));
            checkOutput("clear pops", VW'(popCount - popBase), VW'(0));
            repeat (2) tick();
            for (int a = 0; a < DEPTH; a++) hostRead(a, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
